tick_timer: RTL

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/tick_timer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tick_timer.sv
// Tick timer: synchronises an external divided clock, turns its rising edges into
// one-cycle ticks, and counts a loaded number of them. `TICK_TIMER_AUTO_RELOAD_EN` selects periodic mode.
module tick_timer #(
    parameter int unsigned TIMER_WIDTH = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk_FPGA,
    input  logic                   reset,
    input  logic                   clock_signal,
    input  logic                   start,
    input  logic                   stop,
    input  logic [TIMER_WIDTH-1:0] load_value,
    output logic                   tick,
    output logic                   busy,
    output logic                   done,
    output logic [TIMER_WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   prev;
    logic                   sync_out;

`ifdef TICK_TIMER_AUTO_RELOAD_EN
    logic [TIMER_WIDTH-1:0] reload_reg;
`endif

    assign sync_out = sync_chain[SYNC_STAGES-1];

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            sync_chain <= '0;
            prev       <= 1'b0;
            tick       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], clock_signal};
            prev       <= sync_out;
            tick       <= sync_out & ~prev;
        end
    end

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (load_value != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // stop takes priority over a coincident final tick
                if (stop) begin
                    state_next = IDLE;
                end else if (tick && (count <= TIMER_WIDTH'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
`ifdef TICK_TIMER_AUTO_RELOAD_EN
                if (!stop && (reload_reg != '0)) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= load_value;
                    end
                end
                RUN: begin
                    if (!stop && tick && (count != '0)) begin
                        count <= count - TIMER_WIDTH'(1);
                    end
                end
`ifdef TICK_TIMER_AUTO_RELOAD_EN
                DONE: begin
                    if (!stop && (reload_reg != '0)) begin
                        count <= reload_reg;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef TICK_TIMER_AUTO_RELOAD_EN
    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            reload_reg <= '0;
        end else if ((state == IDLE) && start && (load_value != '0)) begin
            reload_reg <= load_value;
        end
    end
`endif

endmodule
